branch_resolve: RTL and testbench
=================================

# branch_resolve

Branch resolution and redirect unit at the EX/MEM boundary. It evaluates each branch/jump in EX and registers the true outcome into MEM. It drives the feedback the IF-stage predictor consumes: `mem_pc`, `mem_is_taken`, `t_addr`, `PCSrc` and `miss_predict`. On a misprediction it sequences the PC redirect and the pipeline flush.

## Interface
- `XLEN`, 32, datapath/PC width
- `FLUSH_CYCLES`, 2, cycles `flush` stays high per misprediction (≥1)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `ex_valid`  in  1  EX holds a live instruction
- `ex_is_branch`  in  1  conditional B-type branch in EX
- `ex_is_jal` / `ex_is_jalr`  in  1  unconditional jumps in EX
- `ex_pc`  in  XLEN  PC of EX instruction
- `ex_imm`  in  XLEN  sign-extended immediate
- `ex_rs1`, `ex_rs2`  in  XLEN  forwarded operands
- `ex_funct3`  in  3  branch condition
- `ex_pred_taken`  in  1  IF prediction carried down the pipe
- `ex_pred_target`  in  XLEN  IF predicted target
- `stall`  in  1  hold MEM register
- `mem_pc`  out  XLEN  PC of resolved instruction
- `mem_is_taken`  out  1  actual direction
- `t_addr`  out  XLEN  actual target
- `upd_valid`  out  1  one-cycle predictor/BTB update strobe
- `miss_predict`  out  1  resolved instruction was mispredicted
- `PCSrc`  out  1  one-cycle redirect request to IF
- `redirect_pc`  out  XLEN  PC IF must load when `PCSrc`=1
- `flush`  out  1  squash IF/ID and ID/EX

## Operation
- **Resolve (combinational, EX):**
  - funct3 decoding: 000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu.
  - funct3 010/011: not-taken.
  - jal/jalr: always taken.
  - Targets: branch/jal = `ex_pc+ex_imm`; jalr = `(ex_rs1+ex_imm) & ~1`. Add modulo 2^XLEN.
- **Mispredict:** `actual_taken != ex_pred_taken`, or (both taken and `target != ex_pred_target`).
- **Redirect target:** `redirect_pc` = target if actual taken, else `ex_pc+4`.
- **MEM register:** loads when `!stall` and FSM is IDLE. A resolvable instruction is `ex_valid` & (branch|jal|jalr). Non-resolvable or invalid EX loads a bubble (valid=0).
- **FSM states:** IDLE, REDIRECT, FLUSH.
  - IDLE → REDIRECT when the newly loaded MEM entry is a valid mispredict.
  - REDIRECT → FLUSH if `FLUSH_CYCLES`>1, else → IDLE.
  - FLUSH counts down and → IDLE after `FLUSH_CYCLES-1` cycles.
- **Squash:** while not IDLE, `ex_valid` is ignored; those instructions are wrong-path. A mispredict cannot arrive during FLUSH.
- **Outputs in REDIRECT:** `PCSrc`=1 and `flush`=1. In FLUSH: `flush`=1 only.
- **Strobes:** `upd_valid` and `miss_predict` pulse exactly one cycle per resolved instruction, even if `stall` holds the entry longer. `mem_*` hold their values until the next load.
- **Reset:** all outputs 0, FSM IDLE, counter 0. Asserting `rst` mid-flush aborts the sequence immediately.

## Timing
- EX resolve in cycle N. At edge N→N+1, the `mem_*` outputs, `upd_valid` and `miss_predict` become valid for cycle N+1.
- Mispredict: `PCSrc`=1 in N+1, so IF loads `redirect_pc` at edge N+1→N+2. `flush` is high in cycles N+1 … N+FLUSH_CYCLES.
- Penalty = FLUSH_CYCLES+1 cycles. Correct prediction adds 0 bubbles.
- Back-to-back correctly predicted branches resolve one per cycle.
- `PCSrc` overrides `stall`: a redirect is never delayed.

## Configuration
- `BRU_PERF_CNT_EN` defined:
  - Adds outputs `perf_branches` (out, 32) and `perf_mispredicts` (out, 32).
  - Each increments on `upd_valid` and `upd_valid&miss_predict` respectively.
  - Both saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `bru_pkg`: funct3 localparams (`F3_BEQ`…`F3_BGEU`), FSM state enum `bru_state_t`, default `XLEN`.
- Sub-module `branch_cmp`: purely combinational; produces condition evaluation and target/fall-through computation. The top holds the MEM register, FSM, flush counter and optional perf counters.

## Test plan
- **beq hit:** `rs1=rs2=5`, pred taken, target 0x120 correct, pc 0x100 imm 0x20 → next cycle `upd_valid`=1, `mem_is_taken`=1, `t_addr`=0x120, `PCSrc`=0, `flush`=0.
- **bne mispredict:** pc 0x40, `rs1=rs2`, pred taken → `miss_predict`=1, `PCSrc`=1 one cycle, `redirect_pc`=0x44, `flush` high 2 cycles. EX instructions during flush produce no `upd_valid`.
- **jalr target mismatch:** `rs1`=0x203, imm 0, pred taken target 0x300 → `t_addr`=0x202, mispredict, `redirect_pc`=0x202.
- **Signed vs unsigned:** `rs1`=0xFFFF_FFFF, `rs2`=1. blt → taken; bltu → not-taken.
- **Stall hold:** branch resolved then `stall`=1 for 3 cycles → `mem_*` held, `upd_valid` high only the first cycle.
- **Reset mid-flush:** drop `rst` in second flush cycle → `flush`, `PCSrc` and `upd_valid` go 0 asynchronously. After release, the FSM is IDLE and perf counters (if `BRU_PERF_CNT_EN`) read 0.

Source files
------------

// File: rtl/bru_pkg.sv
// bru_pkg: shared funct3 codes, FSM state type and default width for the branch resolve unit
package bru_pkg;
    localparam int BRU_XLEN = 32;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} bru_state_t;
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational branch condition, target and fall-through evaluation
// in:  is_branch/is_jal/is_jalr kind, pc, imm, rs1, rs2, funct3
// out: taken (actual direction), target (pc+imm or (rs1+imm)&~1), fall_through (pc+4)
module branch_cmp
    import bru_pkg::*;
#(
    parameter int XLEN = BRU_XLEN
) (
    input  logic            is_branch,
    input  logic            is_jal,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] fall_through
);
    logic eq, lt, ltu, cond;
    assign eq  = rs1 == rs2;
    assign lt  = $signed(rs1) < $signed(rs2);
    assign ltu = rs1 < rs2;
    // funct3 010/011 are not branch conditions and resolve as not-taken
    assign cond = funct3 == F3_BEQ  ? eq   :
                  funct3 == F3_BNE  ? !eq  :
                  funct3 == F3_BLT  ? lt   :
                  funct3 == F3_BGE  ? !lt  :
                  funct3 == F3_BLTU ? ltu  :
                  funct3 == F3_BGEU ? !ltu : 1'b0;
    assign taken        = is_jal | is_jalr | (is_branch & cond);
    assign target       = is_jalr ? ((rs1 + imm) & ~XLEN'(1)) : pc + imm;
    assign fall_through = pc + XLEN'(4);
endmodule

// File: rtl/branch_resolve.sv
// branch_resolve: EX/MEM branch resolution, predictor feedback and mispredict redirect/flush sequencing
// in:  clk, rst (async active-low), ex_* instruction/operands/prediction, stall
// out: mem_pc, mem_is_taken, t_addr, upd_valid, miss_predict, PCSrc, redirect_pc, flush
// BRU_PERF_CNT_EN: adds saturating perf_branches / perf_mispredicts counters
module branch_resolve
    import bru_pkg::*;
#(
    parameter int XLEN         = BRU_XLEN,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [2:0]      ex_funct3,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            stall,
    output logic [XLEN-1:0] mem_pc,
    output logic            mem_is_taken,
    output logic [XLEN-1:0] t_addr,
    output logic            upd_valid,
    output logic            miss_predict,
    output logic            PCSrc,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    bru_state_t      state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            taken, resolvable, mispred, load, resolve;
    logic [XLEN-1:0] target, fall_through;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .is_branch    (ex_is_branch),
        .is_jal       (ex_is_jal),
        .is_jalr      (ex_is_jalr),
        .pc           (ex_pc),
        .imm          (ex_imm),
        .rs1          (ex_rs1),
        .rs2          (ex_rs2),
        .funct3       (ex_funct3),
        .taken        (taken),
        .target       (target),
        .fall_through (fall_through)
    );

    assign resolvable = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr);
    assign mispred    = (taken != ex_pred_taken) | (taken & ex_pred_taken & (target != ex_pred_target));
    // outside IDLE the EX instruction is wrong-path, so nothing loads
    assign load       = !stall && state == S_IDLE;
    assign resolve    = load & resolvable;
    assign PCSrc      = state == S_REDIRECT;
    assign flush      = state != S_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // FLUSH lasts FLUSH_CYCLES-1 cycles after the single REDIRECT cycle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == S_IDLE) begin
            state_nx = (resolve & mispred) ? S_REDIRECT : S_IDLE;
        end else if (state == S_REDIRECT) begin
            state_nx = FLUSH_CYCLES > 1 ? S_FLUSH : S_IDLE;
            cnt_nx   = CW'(FLUSH_CYCLES - 2);
        end else begin
            state_nx = cnt == '0 ? S_IDLE : S_FLUSH;
            cnt_nx   = cnt == '0 ? '0 : cnt - 1'b1;
        end
    end

    // strobes come only from a fresh load, so a stalled entry pulses once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_pc       <= '0;
            mem_is_taken <= 1'b0;
            t_addr       <= '0;
            redirect_pc  <= '0;
            upd_valid    <= 1'b0;
            miss_predict <= 1'b0;
        end else begin
            upd_valid    <= resolve;
            miss_predict <= resolve & mispred;
            if (resolve) begin
                mem_pc       <= ex_pc;
                mem_is_taken <= taken;
                t_addr       <= target;
                redirect_pc  <= taken ? target : fall_through;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (upd_valid && !(&perf_branches)) perf_branches <= perf_branches + 1'b1;
            if (upd_valid && miss_predict && !(&perf_mispredicts)) perf_mispredicts <= perf_mispredicts + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed scoreboard bench for branch_resolve
module tb_branch_resolve;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_pred_taken, stall;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2, ex_pred_target;
    logic [2:0]  ex_funct3;
    logic [31:0] mem_pc, t_addr, redirect_pc;
    logic        mem_is_taken, upd_valid, miss_predict, PCSrc, flush;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_resolve #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_funct3      (ex_funct3),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .stall          (stall),
        .mem_pc         (mem_pc),
        .mem_is_taken   (mem_is_taken),
        .t_addr         (t_addr),
        .upd_valid      (upd_valid),
        .miss_predict   (miss_predict),
        .PCSrc          (PCSrc),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic        mp;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   n_br  = 0;
    int   n_mp  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] a,
                         input logic [31:0] c, input logic pt, input logic [31:0] ptg);
        ex_valid       = 1'b1;
        ex_is_branch   = b;
        ex_is_jal      = j;
        ex_is_jalr     = jr;
        ex_funct3      = f3;
        ex_pc          = pc;
        ex_imm         = imm;
        ex_rs1         = a;
        ex_rs2         = c;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
    endtask

    task automatic expect_res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                              input logic mp, input logic [31:0] rpc);
        sb.push_back('{pc: pc, tk: tk, tgt: tgt, mp: mp, rpc: rpc});
        n_br++;
        if (mp) n_mp++;
    endtask

    task automatic idle();
        ex_valid     = 1'b0;
        ex_is_branch = 1'b0;
        ex_is_jal    = 1'b0;
        ex_is_jalr   = 1'b0;
    endtask

    // advance one cycle, then compare the MEM outputs against the oldest expectation
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chkb("upd_valid", upd_valid, 1'b1);
            chk("mem_pc", mem_pc, e.pc);
            chkb("mem_is_taken", mem_is_taken, e.tk);
            chk("t_addr", t_addr, e.tgt);
            chkb("miss_predict", miss_predict, e.mp);
            chkb("PCSrc", PCSrc, e.mp);
            if (e.mp) begin
                chk("redirect_pc", redirect_pc, e.rpc);
                chkb("flush_redirect", flush, 1'b1);
            end
        end else begin
            chkb("no_upd", upd_valid, 1'b0);
            chkb("no_miss", miss_predict, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0;
        idle();
        ex_funct3 = 3'b0;
        ex_pc = '0;
        ex_imm = '0;
        ex_rs1 = '0;
        ex_rs2 = '0;
        ex_pred_taken = 1'b0;
        ex_pred_target = '0;
        #12;
        chk("rst_mem_pc", mem_pc, 32'h0);
        chk("rst_t_addr", t_addr, 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chkb("rst_taken", mem_is_taken, 1'b0);
        chkb("rst_upd", upd_valid, 1'b0);
        chkb("rst_miss", miss_predict, 1'b0);
        chkb("rst_PCSrc", PCSrc, 1'b0);
        chkb("rst_flush", flush, 1'b0);
`ifdef BRU_PERF_CNT_EN
        chk("rst_perf_br", perf_branches, 32'h0);
        chk("rst_perf_mp", perf_mispredicts, 32'h0);
`endif
        #5;
        rst = 1'b1;

        // beq hit
        drive(1, 0, 0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1, 32'h120);
        expect_res(32'h100, 1, 32'h120, 0, 32'h120);
        tick();
        chkb("beq_flush", flush, 1'b0);

        // back-to-back correct predictions, signed vs unsigned, undefined funct3
        drive(1, 0, 0, 3'b100, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 1, 32'h210);
        expect_res(32'h200, 1, 32'h210, 0, 32'h210);
        tick();
        drive(1, 0, 0, 3'b110, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 0, 32'h0);
        expect_res(32'h200, 0, 32'h210, 0, 32'h204);
        tick();
        drive(1, 0, 0, 3'b010, 32'h240, 32'h8, 32'd1, 32'd1, 0, 32'h0);
        expect_res(32'h240, 0, 32'h248, 0, 32'h244);
        tick();
        drive(1, 0, 0, 3'b101, 32'h260, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 0, 32'h0);
        expect_res(32'h260, 0, 32'h250, 0, 32'h264);
        tick();
        drive(1, 0, 0, 3'b111, 32'hFFFF_FFF0, 32'h20, 32'd9, 32'd9, 1, 32'h10);
        expect_res(32'hFFFF_FFF0, 1, 32'h10, 0, 32'h10);
        tick();
        drive(0, 0, 1, 3'b000, 32'h190, 32'h11, 32'h1000, 32'h0, 1, 32'h1010);
        expect_res(32'h190, 1, 32'h1010, 0, 32'h1010);
        tick();
        idle();
        tick();

        // bne mispredict with wrong-path instruction squashed during flush
        drive(1, 0, 0, 3'b001, 32'h40, 32'h40, 32'd7, 32'd7, 1, 32'h80);
        expect_res(32'h40, 0, 32'h80, 1, 32'h44);
        tick();
        drive(0, 1, 0, 3'b000, 32'h44, 32'h100, 32'h0, 32'h0, 0, 32'h0);
        tick();
        chkb("bne_flush2", flush, 1'b1);
        chkb("bne_pcsrc2", PCSrc, 1'b0);
        idle();
        tick();
        chkb("bne_flush_end", flush, 1'b0);
        chkb("bne_pcsrc_end", PCSrc, 1'b0);

        // jal predicted not-taken
        drive(0, 1, 0, 3'b000, 32'h500, 32'h80, 32'h0, 32'h0, 0, 32'h0);
        expect_res(32'h500, 1, 32'h580, 1, 32'h580);
        tick();
        idle();
        tick();
        chkb("jal_flush2", flush, 1'b1);
        tick();
        chkb("jal_flush_end", flush, 1'b0);

        // jalr target mismatch
        drive(0, 0, 1, 3'b000, 32'h180, 32'h0, 32'h203, 32'h0, 1, 32'h300);
        expect_res(32'h180, 1, 32'h202, 1, 32'h202);
        tick();
        idle();
        tick();
        chkb("jalr_flush2", flush, 1'b1);
        tick();
        chkb("jalr_flush_end", flush, 1'b0);

        // stall hold: the would-be mispredict in EX must not load
        drive(1, 0, 0, 3'b000, 32'h300, 32'h8, 32'd3, 32'd3, 1, 32'h308);
        expect_res(32'h300, 1, 32'h308, 0, 32'h308);
        tick();
        stall = 1'b1;
        drive(1, 0, 0, 3'b001, 32'h400, 32'h10, 32'd1, 32'd2, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_mem_pc", mem_pc, 32'h300);
            chk("stall_t_addr", t_addr, 32'h308);
            chkb("stall_flush", flush, 1'b0);
        end
        stall = 1'b0;
        idle();
        tick();
`ifdef BRU_PERF_CNT_EN
        chk("perf_branches", perf_branches, 32'(n_br));
        chk("perf_mispredicts", perf_mispredicts, 32'(n_mp));
`endif

        // reset in the second flush cycle
        drive(1, 0, 0, 3'b000, 32'h600, 32'h40, 32'd1, 32'd2, 1, 32'h640);
        expect_res(32'h600, 0, 32'h640, 1, 32'h604);
        tick();
        idle();
        tick();
        chkb("rmf_flush_before", flush, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chkb("rmf_flush", flush, 1'b0);
        chkb("rmf_PCSrc", PCSrc, 1'b0);
        chkb("rmf_upd", upd_valid, 1'b0);
        chk("rmf_mem_pc", mem_pc, 32'h0);
`ifdef BRU_PERF_CNT_EN
        chk("rmf_perf_br", perf_branches, 32'h0);
        chk("rmf_perf_mp", perf_mispredicts, 32'h0);
`endif
        #3;
        rst = 1'b1;
        tick();
        chkb("post_rst_flush", flush, 1'b0);
        drive(1, 0, 0, 3'b000, 32'h700, 32'h4, 32'd6, 32'd6, 1, 32'h704);
        expect_res(32'h700, 1, 32'h704, 0, 32'h704);
        tick();
        chkb("post_rst_idle_flush", flush, 1'b0);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
